// File: rtl/hs_ram_arbiter_pkg.sv
// Shared types and helpers for the hiscore / CPU work-RAM arbiter.
// No logic: state encoding plus timer sizing helper.
// No flow control here; consumed by the arbiter and its timer.
package hs_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETTLE,
        GRANT,
        DRAIN
    } hs_arb_state_t;

    // Timer must hold TIMEOUT itself, hence the +1.
    function automatic int hs_arb_timer_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/hs_ram_arbiter_if.sv
// Bundle of CPU request, hiscore request, RAM port and status signals.
// Pure wiring; no latency.
// Level-based signalling; no backpressure beyond the grant/pause handshake.
// Ports: slave = arbiter side, master = environment (CPU core, hiscore, RAM).
interface hs_ram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_we;
    logic          cpu_halted;
    logic [AW-1:0] hs_address;
    logic [DW-1:0] hs_data_in;
    logic          hs_write;
    logic          hs_access;
    logic [DW-1:0] ram_q;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic          pause_req;
    logic          hs_grant;
    logic [DW-1:0] hs_data_out;
    logic          hs_rd_valid;
    logic          timeout_err;

    modport slave (
        input  cpu_addr, cpu_din, cpu_we, cpu_halted,
        input  hs_address, hs_data_in, hs_write, hs_access,
        input  ram_q,
        output ram_addr, ram_din, ram_we,
        output pause_req, hs_grant, hs_data_out, hs_rd_valid, timeout_err
    );

    modport master (
        output cpu_addr, cpu_din, cpu_we, cpu_halted,
        output hs_address, hs_data_in, hs_write, hs_access,
        output ram_q,
        input  ram_addr, ram_din, ram_we,
        input  pause_req, hs_grant, hs_data_out, hs_rd_valid, timeout_err
    );
endinterface

// File: rtl/hs_ram_arbiter_timer.sv
// Loadable down-counter that saturates at zero; shared by settle/hold/timeout.
// Load takes effect on the next clock; zero flag is combinational from the count.
// No backpressure; counts every cycle unless loaded.
// Ports: clk/rst, load + load_val, zero flag.
module hs_arb_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hs_ram_arbiter.sv
// Shares the CPU work-RAM port with the hiscore engine via CPU pause/halt handshake.
// CPU path is combinational (zero latency); hiscore read data returns 2 cycles after address.
// Hiscore waits on hs_grant; CPU is held off through pause_req until it acknowledges halt.
// Ports: clk_sys, reset (async, active-high), bus (slave modport of hs_ram_arbiter_if).
module hs_ram_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int SETTLE  = 4,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk_sys,
    input  logic               reset,
    hs_ram_arbiter_if.slave    bus
);
    import hs_arb_pkg::*;

    localparam int TW = hs_arb_timer_w(TIMEOUT);

    // The timer is loaded with N-1 so that a phase lasts exactly N cycles:
    // the transition fires on the cycle the counter reads zero.
    localparam logic [TW-1:0] TMR_TIMEOUT = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_SETTLE  = TW'(SETTLE - 1);
    localparam logic [TW-1:0] TMR_HOLD    = TW'(HOLD - 1);

    hs_arb_state_t state, state_nxt;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic          err_set;
    logic          err_clr;
    logic          hs_side;
    logic          we_mux;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] din_mux;

    logic          timeout_err_q;
    logic          rd_pend;
    logic          rd_valid_q;
    logic [DW-1:0] hs_data_q;

    hs_arb_timer #(.W(TW)) u_timer (
        .clk      (clk_sys),
        .rst      (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= hs_arb_pkg::IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        hs_side   = 1'b0;
        we_mux    = bus.cpu_we;

        case (state)
            hs_arb_pkg::IDLE: begin
                if (bus.hs_access) begin
                    state_nxt = hs_arb_pkg::REQ;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_TIMEOUT;
                end
            end
            hs_arb_pkg::REQ: begin
                if (bus.cpu_halted) begin
                    state_nxt = hs_arb_pkg::SETTLE;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_SETTLE;
                end else if (!bus.hs_access) begin
                    state_nxt = hs_arb_pkg::IDLE;
                end else if (tmr_zero) begin
                    state_nxt = hs_arb_pkg::IDLE;
                    err_set   = 1'b1;
                end
            end
            hs_arb_pkg::SETTLE: begin
                // CPU still owns the mux, but its writes are blocked while
                // the halted bus settles.
                we_mux = 1'b0;
                if (!bus.hs_access) begin
                    state_nxt = hs_arb_pkg::IDLE;
                end else if (tmr_zero) begin
                    state_nxt = hs_arb_pkg::GRANT;
                    err_clr   = 1'b1;
                end
            end
            hs_arb_pkg::GRANT: begin
                // Hiscore write wins; any concurrent CPU write is dropped.
                hs_side = 1'b1;
                we_mux  = bus.hs_write;
                if (!bus.hs_access) begin
                    state_nxt = hs_arb_pkg::DRAIN;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_HOLD;
                end
            end
            hs_arb_pkg::DRAIN: begin
                hs_side = 1'b1;
                we_mux  = 1'b0;
                if (tmr_zero) begin
                    state_nxt = hs_arb_pkg::IDLE;
                end
            end
            default: begin
                state_nxt = hs_arb_pkg::IDLE;
            end
        endcase

        addr_mux = hs_side ? bus.hs_address : bus.cpu_addr;
        din_mux  = hs_side ? bus.hs_data_in : bus.cpu_din;
    end

    // Read return: address in GRANT at N, RAM data at N+1, registered at N+2.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            timeout_err_q <= 1'b0;
            rd_pend       <= 1'b0;
            rd_valid_q    <= 1'b0;
            hs_data_q     <= '0;
        end else begin
            if (err_set) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
            rd_pend    <= (state == hs_arb_pkg::GRANT) && !bus.hs_write;
            rd_valid_q <= rd_pend;
            if (rd_pend) begin
                hs_data_q <= bus.ram_q;
            end
        end
    end

    assign bus.ram_addr    = addr_mux;
    assign bus.ram_din     = din_mux;
    assign bus.ram_we      = we_mux;
    assign bus.pause_req   = (state != hs_arb_pkg::IDLE);
    assign bus.hs_grant    = (state == hs_arb_pkg::GRANT);
    assign bus.hs_data_out = hs_data_q;
    assign bus.hs_rd_valid = rd_valid_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: grant timing, write/read, collision,
// drain, timeout, async reset in GRANT, and abort with CPU already halted.
// Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
module tb_hs_ram_arbiter;

    logic clk_sys;
    logic reset;
    int   n_chk;
    int   n_err;

    hs_ram_arbiter_if #(.AW(16), .DW(8)) bus ();

    hs_ram_arbiter #(
        .AW(16), .DW(8), .SETTLE(4), .HOLD(2), .TIMEOUT(16)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    // Behavioural work RAM with one-cycle registered read.
    logic [7:0] mem [0:65535];
    always @(posedge clk_sys) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_q <= mem[bus.ram_addr];
    end

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        bus.cpu_addr   = 16'h1234;
        bus.cpu_din    = 8'h5A;
        bus.cpu_we     = 1'b0;
        bus.cpu_halted = 1'b0;
        bus.hs_address = 16'h0000;
        bus.hs_data_in = 8'h00;
        bus.hs_write   = 1'b0;
        bus.hs_access  = 1'b0;
        #2;
        chk("rst_pause",    bus.pause_req,   0);
        chk("rst_grant",    bus.hs_grant,    0);
        chk("rst_we",       bus.ram_we,      0);
        chk("rst_tmo",      bus.timeout_err, 0);
        chk("rst_rdv",      bus.hs_rd_valid, 0);
        chk("rst_dout",     bus.hs_data_out, 0);
        chk("rst_addr",     bus.ram_addr,    16'h1234);
        chk("rst_din",      bus.ram_din,     8'h5A);
        cyc();
        cyc();
        reset = 1'b0;

        // Normal grant: halt arrives 3 cycles after pause_req.
        cyc();                                  // cycle 0
        bus.hs_access = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 16'h1000;
        bus.cpu_din   = 8'h77;
        #1;
        chk("c0_pause", bus.pause_req, 0);
        chk("c0_we",    bus.ram_we,    1);
        cyc(); #1;                              // cycle 1
        chk("c1_pause", bus.pause_req, 1);
        chk("c1_we",    bus.ram_we,    1);
        cyc();                                  // cycle 2
        cyc();                                  // cycle 3
        cyc();                                  // cycle 4: halt
        bus.cpu_halted = 1'b1;
        #1;
        chk("c4_grant", bus.hs_grant, 0);
        for (int i = 1; i <= 4; i++) begin      // cycles 5..8: SETTLE
            cyc(); #1;
            chk("settle_grant", bus.hs_grant, 0);
            chk("settle_we",    bus.ram_we,   0);
            chk("settle_addr",  bus.ram_addr, 16'h1000);
        end
        cyc(); #1;                              // cycle 9 = k+SETTLE+1
        chk("grant_on",  bus.hs_grant, 1);
        chk("grant_we0", bus.ram_we,   0);

        // Write 0xA5 to 0x6100 then read it back.
        bus.hs_address = 16'h6100;
        bus.hs_data_in = 8'hA5;
        bus.hs_write   = 1'b1;
        #1;
        chk("wr_we",   bus.ram_we,   1);
        chk("wr_addr", bus.ram_addr, 16'h6100);
        chk("wr_din",  bus.ram_din,  8'hA5);
        cyc();                                  // N: read address
        bus.hs_write = 1'b0;
        #1;
        chk("rd_n_vld", bus.hs_rd_valid, 0);
        cyc(); #1;                              // N+1
        chk("rd_n1_vld", bus.hs_rd_valid, 0);
        cyc(); #1;                              // N+2
        chk("rd_n2_vld", bus.hs_rd_valid, 1);
        chk("rd_data",   bus.hs_data_out, 8'hA5);

        // Collision: CPU 0x11 and hiscore 0x22 both to 0x6000.
        bus.cpu_we     = 1'b1;
        bus.cpu_addr   = 16'h6000;
        bus.cpu_din    = 8'h11;
        bus.hs_write   = 1'b1;
        bus.hs_address = 16'h6000;
        bus.hs_data_in = 8'h22;
        #1;
        chk("col_we",  bus.ram_we,  1);
        chk("col_din", bus.ram_din, 8'h22);
        cyc();                                  // M: read back 0x6000
        bus.hs_write = 1'b0;
        bus.cpu_addr = 16'h1000;
        cyc();
        cyc(); #1;                              // M+2
        chk("col_vld",  bus.hs_rd_valid, 1);
        chk("col_data", bus.hs_data_out, 8'h22);

        // Drop intent: DRAIN for HOLD cycles, then IDLE.
        bus.hs_access  = 1'b0;
        bus.hs_address = 16'h6200;
        cyc(); #1;
        chk("drn_grant", bus.hs_grant,  0);
        chk("drn_we",    bus.ram_we,    0);
        chk("drn_addr",  bus.ram_addr,  16'h6200);
        chk("drn_pause", bus.pause_req, 1);
        cyc(); #1;
        chk("drn2_pause", bus.pause_req, 1);
        cyc(); #1;
        chk("idle_pause", bus.pause_req, 0);
        chk("idle_addr",  bus.ram_addr,  16'h1000);
        chk("idle_we",    bus.ram_we,    1);
        bus.cpu_halted = 1'b0;
        bus.cpu_we     = 1'b0;

        // Timeout: no halt for 16 REQ cycles.
        cyc();                                  // t0
        bus.hs_access = 1'b1;
        cyc(); #1;                              // t1
        chk("to_t1_pause", bus.pause_req, 1);
        repeat (15) cyc();                      // t16
        #1;
        chk("to_t16_pause", bus.pause_req,   1);
        chk("to_t16_err",   bus.timeout_err, 0);
        cyc(); #1;                              // t17
        chk("to_t17_pause", bus.pause_req,   0);
        chk("to_t17_err",   bus.timeout_err, 1);
        cyc();                                  // t18: REQ again, halt now
        bus.cpu_halted = 1'b1;
        #1;
        chk("to_t18_pause", bus.pause_req,   1);
        repeat (4) cyc();                       // t22: last SETTLE cycle
        #1;
        chk("to_t22_err",   bus.timeout_err, 1);
        chk("to_t22_grant", bus.hs_grant,    0);
        cyc(); #1;                              // t23: GRANT
        chk("to_t23_grant", bus.hs_grant,    1);
        chk("to_t23_err",   bus.timeout_err, 0);

        // Async reset in GRANT.
        bus.hs_address = 16'h6300;
        bus.cpu_addr   = 16'h1100;
        #1;
        chk("pre_rst_addr", bus.ram_addr, 16'h6300);
        reset = 1'b1;
        #1;
        chk("arst_grant", bus.hs_grant,    0);
        chk("arst_pause", bus.pause_req,   0);
        chk("arst_addr",  bus.ram_addr,    16'h1100);
        chk("arst_dout",  bus.hs_data_out, 0);
        cyc();
        reset         = 1'b0;
        bus.hs_access = 1'b0;

        // Already halted at request: REQ for one cycle, then abort in SETTLE.
        cyc();                                  // a0
        bus.hs_access = 1'b1;
        bus.cpu_we    = 1'b1;
        #1;
        chk("ab_a0_pause", bus.pause_req, 0);
        cyc(); #1;                              // a1: REQ
        chk("ab_a1_pause", bus.pause_req, 1);
        chk("ab_a1_we",    bus.ram_we,    1);
        cyc(); #1;                              // a2: SETTLE
        chk("ab_a2_we",    bus.ram_we,    0);
        chk("ab_a2_grant", bus.hs_grant,  0);
        cyc();                                  // a3: abort
        bus.hs_access = 1'b0;
        #1;
        chk("ab_a3_grant", bus.hs_grant,  0);
        cyc(); #1;                              // a4: IDLE
        chk("ab_a4_pause", bus.pause_req, 0);
        chk("ab_a4_grant", bus.hs_grant,  0);
        chk("ab_a4_we",    bus.ram_we,    1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
